// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
// sync_pkg : shared constants and elaboration helpers for sync_debounce
// Rev 1.0
// ============================================================================
package sync_pkg;

  localparam int MIN_STAGES     = 2;
  localparam int MIN_FILTER_CNT = 1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit params_ok(input int stages, input int filter_cnt);
    return (stages >= MIN_STAGES) && (filter_cnt >= MIN_FILTER_CNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce_if.sv
`default_nettype none
// ============================================================================
// sync_debounce_if : raw inputs and conditioned outputs of sync_debounce
// Rev 1.0
// ============================================================================
interface sync_debounce_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] async_in;
  logic             filter_en;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output async_in,
    output filter_en,
    input  sync_out,
    input  filt_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  async_in,
    input  filter_en,
    output sync_out,
    output filt_out,
    output rise_pulse,
    output fall_pulse
  );

endinterface
`default_nettype wire

// File: rtl/sync_debounce_ch.sv
`default_nettype none
// ============================================================================
// sync_debounce_ch : one channel - synchronizer, stability filter, edge pulses
// Rev 1.0
// ============================================================================
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 4,
  parameter logic RST_BIT    = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_i,
  input  logic filter_en_i,
  output logic sync_o,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              filt_q, filt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              sync_lvl;

  generate
    if (!params_ok(STAGES, FILTER_CNT)) begin : g_param_chk
      $error("sync_debounce_ch: STAGES must be >= 2 and FILTER_CNT >= 1");
    end
  endgenerate

  assign sync_lvl = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RST_BIT}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  // Any cycle where the synced level agrees with filt_out discards the count,
  // so only an uninterrupted run of FILTER_CNT disagreeing cycles is accepted.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (!filter_en_i) begin
      filt_d = sync_lvl;
    end else if (sync_lvl != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      filt_q <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = sync_lvl;
  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// sync_debounce : multi-channel synchronizer + debounce filter + edge pulses
// Rev 1.0
// ============================================================================
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b1}},
  parameter int               FILTER_CNT = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  sync_debounce_if.slave bus
);

  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] filt_lvl;
  logic [WIDTH-1:0] rise_lvl;
  logic [WIDTH-1:0] fall_lvl;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_debounce_ch #(
        .STAGES     (STAGES),
        .FILTER_CNT (FILTER_CNT),
        .RST_BIT    (RST_VAL[i])
      ) u_ch (
        .clk         (clk),
        .n_rst       (n_rst),
        .async_i     (bus.async_in[i]),
        .filter_en_i (bus.filter_en),
        .sync_o      (sync_lvl[i]),
        .filt_o      (filt_lvl[i]),
        .rise_o      (rise_lvl[i]),
        .fall_o      (fall_lvl[i])
      );
    end
  endgenerate

  assign bus.sync_out   = sync_lvl;
  assign bus.filt_out   = filt_lvl;
  assign bus.rise_pulse = rise_lvl;
  assign bus.fall_pulse = fall_lvl;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// tb_sync_debounce : directed + random stimulus against a history-based model
// Rev 1.0
// ============================================================================
module tb_sync_debounce;

  localparam int         WIDTH = 4;
  localparam int         STG   = 2;
  localparam int         FC    = 4;
  localparam logic [3:0] RST   = 4'hF;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] f;
    logic [3:0] r;
    logic [3:0] fl;
  } exp_t;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  sync_debounce_if #(.WIDTH(WIDTH)) bus ();

  sync_debounce #(
    .WIDTH      (WIDTH),
    .STAGES     (STG),
    .RST_VAL    (RST),
    .FILTER_CNT (FC)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: outputs derived from the full input history since reset.
  // filt accepts a new level once the last FC edges all had the filter enabled
  // and all saw a synced level different from the current filtered level.
  initial begin : model
    logic [3:0] a_q[$];
    logic       en_q[$];
    logic [3:0] s_q[$];
    logic [3:0] f_q[$];
    logic [3:0] s_new, f_new, f_prev;
    exp_t       e;
    int         k;
    bit         ok;
    a_q.push_back(4'h0); en_q.push_back(1'b0); s_q.push_back(RST); f_q.push_back(RST);
    forever begin
      @(posedge clk);
      if (!n_rst) begin
        a_q.delete(); en_q.delete(); s_q.delete(); f_q.delete();
        a_q.push_back(4'h0); en_q.push_back(1'b0); s_q.push_back(RST); f_q.push_back(RST);
        e.s = RST; e.f = RST; e.r = 4'h0; e.fl = 4'h0;
      end else begin
        a_q.push_back(bus.async_in);
        en_q.push_back(bus.filter_en);
        k      = a_q.size() - 1;
        s_new  = (k >= STG) ? a_q[k-STG+1] : RST;
        f_prev = f_q[k-1];
        for (int b = 0; b < WIDTH; b++) begin
          if (!en_q[k]) begin
            f_new[b] = s_q[k-1][b];
          end else begin
            ok = (k >= FC);
            for (int j = k - FC + 1; ok && j <= k; j++)
              if (!en_q[j] || s_q[j-1][b] == f_prev[b]) ok = 0;
            f_new[b] = ok ? s_q[k-1][b] : f_prev[b];
          end
        end
        s_q.push_back(s_new);
        f_q.push_back(f_new);
        e.s = s_new; e.f = f_new; e.r = f_new & ~f_prev; e.fl = ~f_new & f_prev;
      end
      sb_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected >=1", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sync_out",   bus.sync_out,   e.s);
        chk("filt_out",   bus.filt_out,   e.f);
        chk("rise_pulse", bus.rise_pulse, e.r);
        chk("fall_pulse", bus.fall_pulse, e.fl);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] a, input int n);
    bus.async_in = a;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; reset takes effect immediately, without a clock edge.
  task automatic do_reset(input int hold);
    n_rst = 1'b0;
    #1;
    chk("rst_sync_out", bus.sync_out,   RST);
    chk("rst_filt_out", bus.filt_out,   RST);
    chk("rst_rise",     bus.rise_pulse, 4'h0);
    chk("rst_fall",     bus.fall_pulse, 4'h0);
    repeat (hold) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin : stim
    int         hold[WIDTH];
    logic [3:0] lvl;
    n_checks      = 0;
    n_fail        = 0;
    n_rst         = 1'b0;
    bus.async_in  = 4'h0;
    bus.filter_en = 1'b1;
    @(negedge clk);

    // Startup with inputs opposite to the reset value
    do_reset(2);
    drive(4'h0, 10);
    drive(4'hF, 12);
    // Glitch shorter than the filter window
    drive(4'hE, 3);
    drive(4'hF, 10);
    // Glitch exactly as long as the filter window
    drive(4'hE, 4);
    drive(4'hF, 12);
    // Bypass single-cycle pulse
    bus.filter_en = 1'b0;
    drive(4'hB, 1);
    drive(4'hF, 6);
    bus.filter_en = 1'b1;
    drive(4'hF, 4);
    // Reset in the middle of a count
    drive(4'hD, 4);
    bus.async_in = 4'hF;
    do_reset(2);
    drive(4'hF, 10);
    // Simultaneous channels, one too short
    drive(4'h5, 2);
    drive(4'hD, 12);
    drive(4'hF, 10);

    for (int b = 0; b < WIDTH; b++) hold[b] = 0;
    lvl = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 7);
        end
        hold[b]--;
      end
      bus.async_in = lvl;
      if ($urandom_range(0, 99) < 3) bus.filter_en = ~bus.filter_en;
      if ($urandom_range(0, 399) == 0) do_reset(2);
      else @(negedge clk);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Parametrised multi-channel input conditioner for asynchronous external signals such as buttons, switches and status lines.
- Each channel has an N-stage synchronizer with a per-bit reset value, followed by a stability (debounce) filter and single-cycle edge-pulse generation.
- Sits at the chip/board boundary in front of any FSM that consumes raw external inputs.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchronizer flop count; legal range >= 2.
- RST_VAL, {WIDTH{1'b1}}, per-bit reset value of every sync stage and of filt_out.
- FILTER_CNT, 4, consecutive synchronized cycles a new level must hold before acceptance; legal range >= 1.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- async_in  input  WIDTH  raw asynchronous inputs.
- filter_en  input  1  1 = debounce active; 0 = filter bypassed. Synchronous to clk.
- sync_out  output  WIDTH  synchronized, unfiltered level (last sync stage).
- filt_out  output  WIDTH  debounced level.
- rise_pulse  output  WIDTH  one-cycle pulse on a filt_out 0->1 transition.
- fall_pulse  output  WIDTH  one-cycle pulse on a filt_out 1->0 transition.

Behaviour:
- Reset: asynchronous on n_rst low, active-low. The design is clocked by clk.
- Reset values:
  - all sync stages = RST_VAL; sync_out = RST_VAL; filt_out = RST_VAL.
  - counters = 0; rise_pulse = 0; fall_pulse = 0.
- Sync chain: a shift of STAGES flops per bit. sync_out changes exactly STAGES rising edges after async_in is first sampled at its new level.
- Filter, per channel i, evaluated each edge with filter_en = 1:
  - sync_out[i] == filt_out[i]: cnt[i] <= 0.
  - Values differ and cnt[i] < FILTER_CNT-1: cnt[i] <= cnt[i]+1.
  - Values differ and cnt[i] == FILTER_CNT-1: filt_out[i] <= sync_out[i]; cnt[i] <= 0.
- Filter latency: a level held FILTER_CNT consecutive sync cycles reaches filt_out. Total async_in -> filt_out latency is STAGES + FILTER_CNT edges.
- Glitch rejection: any excursion shorter than FILTER_CNT cycles is rejected, and the counter restarts from 0.
- Counter width: $clog2(FILTER_CNT+1). The counter never exceeds FILTER_CNT-1, so no wrap-around.
- Bypass (filter_en = 0):
  - filt_out <= sync_out every edge (latency STAGES+1).
  - cnt <= 0.
  - Pulses are still generated.
- Switching filter_en 0->1 mid-operation: counting starts from 0 on the following edge. filt_out holds its current value.
- Edge pulses:
  - Registered; asserted in the same cycle filt_out shows the new value.
  - High for exactly one cycle per transition.
  - rise_pulse[i] and fall_pulse[i] are never both high.
- Reset deassertion generates no pulse, even if async_in differs from RST_VAL. The resulting transition is filtered and pulsed normally later.
- Reset mid-count: all state returns immediately to reset values and any partial count is discarded.
- Channels are fully independent. Simultaneous transitions on several bits are each handled per the rules above.

Decomposition:
- Package sync_pkg:
  - localparam MIN_STAGES = 2.
  - Function cnt_width(int n) returning $clog2(n+1).
  - Parameter-check helper used for elaboration-time assertion of the STAGES and FILTER_CNT ranges.
- Sub-module sync_debounce_ch: one channel containing sync chain, counter, filt_out flop and pulse flops. Parameters STAGES, FILTER_CNT, RST_BIT.
- Top level instantiates sync_debounce_ch WIDTH times in a generate loop, with RST_BIT = RST_VAL[i].

Test Plan:
All scenarios use WIDTH=4, STAGES=2, FILTER_CNT=4, RST_VAL=4'hF.
1. Reset and startup: n_rst=0 with async_in=4'h0 -> sync_out=filt_out=4'hF, pulses 0. After release with async_in held at 0 -> sync_out=0 after edge 2; filt_out=0 after edge 6; fall_pulse=4'hF for one cycle; no pulse at release.
2. Glitch rejection: from steady 4'hF, async_in[0]=0 for 3 cycles -> sync_out[0] dips 3 cycles; filt_out stays 4'hF; no pulses.
3. Exact threshold: async_in[0]=0 for 4 cycles, then 1 -> filt_out[0]=0 six edges after the drop with fall_pulse[0] one cycle. filt_out[0] returns to 1 six edges after the rise with rise_pulse[0] one cycle.
4. Bypass: filter_en=0, async_in[2]=0 for 1 cycle -> filt_out[2] low for one cycle, 3 edges after input; fall_pulse[2] then rise_pulse[2], each one cycle.
5. Reset mid-count: async_in[1]=0; assert n_rst when cnt[1]=2 -> outputs return to 4'hF asynchronously. After release with async_in[1]=1 -> no pulses, filt_out stays 4'hF.
6. Simultaneous channels: bits 1 and 3 go low on the same cycle; bit 3 returns high after 2 cycles -> only filt_out[1] and fall_pulse[1] change; bit 3 is unaffected.
